// File: rtl/gpu_reset_sequencer.sv
// Staged reset sequencer for the GPU clock domain: releases rst_mem, then rst_core, once PLL lock has been stable.
// Optional core soft-reset hold state is compiled in with `define RSTSEQ_SW_RESET_EN.
module gpu_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MEM_TO_CORE_CYCLES = 64,
  parameter int CNT_W              = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
`ifdef RSTSEQ_SW_RESET_EN
  input  logic                  sw_rst_req,
`endif
  output logic                  rst_mem,
  output logic                  rst_core,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_STABLE    = 3'd1;
  localparam logic [2:0] ST_MEM_UP    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
`ifdef RSTSEQ_SW_RESET_EN
  localparam logic [2:0] ST_SW_HOLD   = 3'd4;
`endif

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TO_CORE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;
  logic [2:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   loss_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_reg[SYNC_STAGES-1];

  // A low locked_s in any state past WAIT_LOCK is a lock-loss event and restarts the sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_event = 1'b0;
    case (state_reg)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_event = 1'b1;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = ST_MEM_UP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_MEM_UP: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_event = 1'b1;
        end else if (cnt_reg == MEM_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_event = 1'b1;
        end
`ifdef RSTSEQ_SW_RESET_EN
        else if (sw_rst_req) begin
          state_next = ST_SW_HOLD;
          cnt_next   = '0;
        end
`endif
      end
`ifdef RSTSEQ_SW_RESET_EN
      ST_SW_HOLD: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_event = 1'b1;
        end else if (cnt_reg == MEM_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      default: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode state_next so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_WAIT_LOCK;
      cnt_reg         <= '0;
      lock_loss_count <= '0;
      rst_mem         <= 1'b1;
      rst_core        <= 1'b1;
      ready           <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (loss_event && (lock_loss_count != {LOSS_CNT_W{1'b1}})) begin
        lock_loss_count <= lock_loss_count + 1'b1;
      end
      rst_mem  <= (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE);
      rst_core <= (state_next != ST_RUN);
      ready    <= (state_next == ST_RUN);
    end
  end

endmodule

// File: tb/tb_gpu_reset_sequencer.sv
// Scoreboard bench for gpu_reset_sequencer: a run-length model of lock history predicts outputs every cycle.
// Build with RSTSEQ_SW_RESET_EN defined to also exercise the soft-reset hold.
module tb_gpu_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int M2C  = 4;
  localparam int CW   = 16;
  localparam int LW   = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;
  localparam int RUN_AT   = LOCK + M2C + 1;
`ifdef RSTSEQ_SW_RESET_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic          rst_mem, rst_core, ready;
  logic [LW-1:0] lock_loss_count;

  typedef struct packed {
    logic          rst_mem;
    logic          rst_core;
    logic          ready;
    logic [LW-1:0] loss;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  gpu_reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_STABLE_CYCLES(LOCK),
    .MEM_TO_CORE_CYCLES(M2C),
    .CNT_W(CW),
    .LOSS_CNT_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
`ifdef RSTSEQ_SW_RESET_EN
    .sw_rst_req(sw_rst_req),
`endif
    .rst_mem(rst_mem),
    .rst_core(rst_core),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  // Model: k counts consecutive edges that saw locked_s=1; memory is up once k > LOCK,
  // the core once k > LOCK+M2C. hold counts remaining soft-reset cycles.
  initial begin : model
    int   k;
    int   hold;
    int   loss_m;
    logic hist[$];
    logic ls;
    bit   was_run;
    exp_t e;
    k = 0; hold = 0; loss_m = 0;
    hist = {};
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0; hold = 0; loss_m = 0;
        hist = {};
      end else begin
        ls      = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
        was_run = (k >= RUN_AT) && (hold == 0);
        if (!ls) begin
          if (k > 0 && loss_m < LOSS_MAX) loss_m++;
          k = 0; hold = 0;
        end else begin
          if (hold > 0) hold--;
          else if (SW_EN && was_run && sw_rst_req) hold = M2C;
          if (k < RUN_AT) k++;
        end
        hist.push_back(pll_locked);
        if (hist.size() > SYNC) void'(hist.pop_front());
      end
      e.rst_mem  = !(k >= LOCK + 1);
      e.rst_core = !((k >= RUN_AT) && (hold == 0));
      e.ready    = (k >= RUN_AT) && (hold == 0);
      e.loss     = LW'(loss_m);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cycle_no++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty cycle=%0d: no expected entry for DUT output", cycle_no);
      end else begin
        e = exp_q.pop_front();
        if ({rst_mem, rst_core, ready, lock_loss_count} !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d: got mem=%b core=%b ready=%b loss=%0d, want mem=%b core=%b ready=%b loss=%0d",
                   cycle_no, rst_mem, rst_core, ready, lock_loss_count,
                   e.rst_mem, e.rst_core, e.ready, e.loss);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_lock(input int low_cycles);
    pll_locked = 1'b0;
    cyc(low_cycles);
    pll_locked = 1'b1;
  endtask

  initial begin : driver
    int rate;
    cyc(3);
    rst = 1'b0;
    pll_locked = 1'b1;
    cyc(20);
    $display("scenario power_up: checks=%0d", checks);

    drop_lock(1);
    cyc(20);
    $display("scenario loss_in_run: checks=%0d", checks);

    drop_lock(1);
    cyc(7);
    drop_lock(1);
    cyc(20);
    $display("scenario loss_in_stable: checks=%0d", checks);

    repeat (5) begin
      drop_lock(1);
      cyc(6);
    end
    cyc(20);
    $display("scenario saturation: checks=%0d", checks);

    // Sub-cycle glitch that no clock edge samples.
    @(negedge clk);
    pll_locked = 1'b0;
    #2;
    pll_locked = 1'b1;
    cyc(5);
    $display("scenario short_glitch: checks=%0d", checks);

    drop_lock(1);
    cyc(12);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);
    $display("scenario reset_mid_mem_up: checks=%0d", checks);

`ifdef RSTSEQ_SW_RESET_EN
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    cyc(10);
    drop_lock(1);
    cyc(12);
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    cyc(20);
    sw_rst_req = 1'b1;
    cyc(3);
    sw_rst_req = 1'b0;
    cyc(10);
    $display("scenario sw_reset: checks=%0d", checks);
`endif

    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 2))
        0: rate = 8;
        1: rate = 40;
        default: rate = 400;
      endcase
      for (int i = 0; i < 100; i++) begin
        rst        = ($urandom_range(0, 299) == 0);
        pll_locked = ($urandom_range(0, rate - 1) != 0);
        if (SW_EN) sw_rst_req = ($urandom_range(0, 9) == 0);
        cyc(1);
      end
    end
    rst = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    cyc(3);
    $display("scenario random: checks=%0d", checks);

    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want at most 1", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
